// File: rtl/mcu_stream_sequencer.sv
// Host-side MCU initiator: loads column-major pixels into MCU banks, then runs
// chblk/sop/eop sequences and streams convolution results back to the host.
module mcu_stream_sequencer #(
  parameter int N           = 2,
  parameter int BITS_IMAGEN = 8,
  parameter int BITS_DATA   = 13,
  parameter int BITS_ADDR   = 10,
  parameter int BITS_COLS   = 10
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   i_Start,
  input  logic [BITS_ADDR-1:0]   i_Rows,
  input  logic [BITS_COLS-1:0]   i_Cols,
  input  logic [BITS_IMAGEN-1:0] i_Pix,
  input  logic                   i_PixValid,
  output logic                   o_PixReady,
  output logic [BITS_DATA-1:0]   o_Res,
  output logic                   o_ResValid,
  output logic                   o_Busy,
  output logic                   o_Done,
  output logic [BITS_IMAGEN-1:0] o_Data,
  output logic                   o_WValid,
  output logic [BITS_ADDR-1:0]   o_WAddr,
  output logic [BITS_ADDR-1:0]   o_RAddr,
  output logic                   o_chblk,
  output logic                   o_sop,
  output logic                   o_eop,
  input  logic [BITS_DATA-1:0]   i_MemRes
);

  localparam int BATCH_W = $clog2(N + 3);
  localparam int DCOL_W  = (N > 1) ? $clog2(N) : 1;
  localparam logic [BATCH_W-1:0] FIRST_BATCH = BATCH_W'(N + 2);
  localparam logic [BATCH_W-1:0] NEXT_BATCH  = BATCH_W'(N);
  localparam logic [DCOL_W-1:0]  LAST_DCOL   = DCOL_W'(N - 1);

  typedef enum logic [2:0] {
    S_IDLE, S_LOAD, S_CHBLK, S_RUN, S_DRAIN, S_DCHBLK, S_FLUSH, S_DONE
  } state_t;

  state_t                 state_q, state_d;
  logic [BITS_ADDR-1:0]   rows_q, rows_d;
  logic [BITS_COLS-1:0]   cols_q, cols_d;
  logic [BITS_ADDR-1:0]   row_q, row_d;
  logic [BITS_COLS:0]     col_q, col_d;
  logic [BATCH_W-1:0]     batch_q, batch_d;
  logic [DCOL_W-1:0]      dcol_q, dcol_d;
  logic                   flush_q, flush_d;
  logic [BITS_IMAGEN-1:0] data_q, data_d;
  logic                   wvalid_q, wvalid_d;
  logic [BITS_ADDR-1:0]   waddr_q, waddr_d;
  logic [BITS_ADDR-1:0]   raddr_q, raddr_d;
  logic                   chblk_q, chblk_d;
  logic                   sop_q, sop_d;
  logic                   eop_q, eop_d;
  logic                   done_q, done_d;
  logic                   rdStb_q, rdStb_d;
  logic                   memVld_q, memVld_d;
  logic [BITS_DATA-1:0]   res_q, res_d;
  logic                   resValid_q, resValid_d;

  logic hostCol;
  logic lastRow;

  // Columns at or beyond the image width are zero padding generated internally.
  assign hostCol = col_q < {1'b0, cols_q};
  assign lastRow = row_q == (rows_q - 1'b1);

  assign o_PixReady = (state_q == S_LOAD) && hostCol;
  assign o_Busy     = state_q != S_IDLE;
  assign o_Data     = data_q;
  assign o_WValid   = wvalid_q;
  assign o_WAddr    = waddr_q;
  assign o_RAddr    = raddr_q;
  assign o_chblk    = chblk_q;
  assign o_sop      = sop_q;
  assign o_eop      = eop_q;
  assign o_Done     = done_q;
  assign o_Res      = res_q;
  assign o_ResValid = resValid_q;

  always_comb begin
    state_d    = state_q;
    rows_d     = rows_q;
    cols_d     = cols_q;
    row_d      = row_q;
    col_d      = col_q;
    batch_d    = batch_q;
    dcol_d     = dcol_q;
    flush_d    = flush_q;
    data_d     = data_q;
    wvalid_d   = 1'b0;
    waddr_d    = waddr_q;
    raddr_d    = raddr_q;
    chblk_d    = 1'b0;
    sop_d      = 1'b0;
    eop_d      = 1'b0;
    done_d     = 1'b0;
    rdStb_d    = 1'b0;
    memVld_d   = rdStb_q;
    resValid_d = memVld_q;
    res_d      = memVld_q ? i_MemRes : res_q;

    case (state_q)
      S_IDLE: begin
        if (i_Start) begin
          rows_d  = i_Rows;
          cols_d  = i_Cols;
          batch_d = FIRST_BATCH;
          row_d   = '0;
          col_d   = '0;
          state_d = S_LOAD;
        end
      end
      S_LOAD: begin
        if (!hostCol || i_PixValid) begin
          data_d   = hostCol ? i_Pix : '0;
          waddr_d  = row_q;
          wvalid_d = 1'b1;
          if (lastRow) begin
            row_d   = '0;
            col_d   = col_q + 1'b1;
            state_d = S_CHBLK;
          end else begin
            row_d = row_q + 1'b1;
          end
        end
      end
      S_CHBLK: begin
        chblk_d = 1'b1;
        batch_d = batch_q - 1'b1;
        state_d = (batch_q == BATCH_W'(1)) ? S_RUN : S_LOAD;
      end
      S_RUN: begin
        sop_d   = 1'b1;
        raddr_d = row_q;
        if (lastRow) begin
          row_d   = '0;
          dcol_d  = '0;
          state_d = S_DRAIN;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      S_DRAIN: begin
        eop_d   = 1'b1;
        raddr_d = row_q;
        rdStb_d = 1'b1;
        if (lastRow) begin
          row_d   = '0;
          state_d = S_DCHBLK;
        end else begin
          row_d = row_q + 1'b1;
        end
      end
      S_DCHBLK: begin
        eop_d   = 1'b1;
        chblk_d = 1'b1;
        if (dcol_q == LAST_DCOL) begin
          flush_d = 1'b0;
          state_d = S_FLUSH;
        end else begin
          dcol_d  = dcol_q + 1'b1;
          state_d = S_DRAIN;
        end
      end
      S_FLUSH: begin
        // Two cycles let the last read reach o_Res; another pass remains while
        // fewer columns than the image width have been loaded.
        eop_d   = 1'b1;
        flush_d = 1'b1;
        if (flush_q) begin
          if (hostCol) begin
            batch_d = NEXT_BATCH;
            state_d = S_LOAD;
          end else begin
            state_d = S_DONE;
          end
        end
      end
      S_DONE: begin
        done_d  = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      rows_q     <= '0;
      cols_q     <= '0;
      row_q      <= '0;
      col_q      <= '0;
      batch_q    <= '0;
      dcol_q     <= '0;
      flush_q    <= 1'b0;
      data_q     <= '0;
      wvalid_q   <= 1'b0;
      waddr_q    <= '0;
      raddr_q    <= '0;
      chblk_q    <= 1'b0;
      sop_q      <= 1'b0;
      eop_q      <= 1'b0;
      done_q     <= 1'b0;
      rdStb_q    <= 1'b0;
      memVld_q   <= 1'b0;
      res_q      <= '0;
      resValid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      rows_q     <= rows_d;
      cols_q     <= cols_d;
      row_q      <= row_d;
      col_q      <= col_d;
      batch_q    <= batch_d;
      dcol_q     <= dcol_d;
      flush_q    <= flush_d;
      data_q     <= data_d;
      wvalid_q   <= wvalid_d;
      waddr_q    <= waddr_d;
      raddr_q    <= raddr_d;
      chblk_q    <= chblk_d;
      sop_q      <= sop_d;
      eop_q      <= eop_d;
      done_q     <= done_d;
      rdStb_q    <= rdStb_d;
      memVld_q   <= memVld_d;
      res_q      <= res_d;
      resValid_q <= resValid_d;
    end
  end

endmodule

// File: tb/tb_mcu_stream_sequencer.sv
// Scoreboard bench for mcu_stream_sequencer: expected writes/results are queued
// when an image is issued and a negedge monitor pops them as the DUT strobes.
module tb_mcu_stream_sequencer;

  localparam int N  = 2;
  localparam int BI = 8;
  localparam int BD = 13;
  localparam int BA = 10;
  localparam int BC = 10;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          i_Start = 1'b0;
  logic [BA-1:0] i_Rows = '0;
  logic [BC-1:0] i_Cols = '0;
  logic [BI-1:0] i_Pix = '0;
  logic          i_PixValid = 1'b0;
  logic          o_PixReady;
  logic [BD-1:0] o_Res;
  logic          o_ResValid;
  logic          o_Busy;
  logic          o_Done;
  logic [BI-1:0] o_Data;
  logic          o_WValid;
  logic [BA-1:0] o_WAddr;
  logic [BA-1:0] o_RAddr;
  logic          o_chblk;
  logic          o_sop;
  logic          o_eop;
  logic [BD-1:0] i_MemRes = '0;

  typedef struct {
    logic [BI-1:0] data;
    logic [BA-1:0] addr;
  } wr_t;

  wr_t           wrQ[$];
  logic [BD-1:0] resQ[$];

  int tests = 0;
  int fails = 0;
  int wrCount, resCount, chblkLoad, chblkDrain, sopCycles, doneCount;
  int overlaps = 0;
  int dcolTb = 0;

  mcu_stream_sequencer #(
    .N(N), .BITS_IMAGEN(BI), .BITS_DATA(BD), .BITS_ADDR(BA), .BITS_COLS(BC)
  ) dut (
    .clk(clk), .rst(rst), .i_Start(i_Start), .i_Rows(i_Rows), .i_Cols(i_Cols),
    .i_Pix(i_Pix), .i_PixValid(i_PixValid), .o_PixReady(o_PixReady),
    .o_Res(o_Res), .o_ResValid(o_ResValid), .o_Busy(o_Busy), .o_Done(o_Done),
    .o_Data(o_Data), .o_WValid(o_WValid), .o_WAddr(o_WAddr), .o_RAddr(o_RAddr),
    .o_chblk(o_chblk), .o_sop(o_sop), .o_eop(o_eop), .i_MemRes(i_MemRes)
  );

  always #5 clk = ~clk;

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  // MCU model: result word tagged with bank column, returned one cycle after o_RAddr.
  always @(posedge clk) begin
    if (o_sop) dcolTb <= 0;
    else if (o_eop && o_chblk) dcolTb <= dcolTb + 1;
    i_MemRes <= BD'(32'h0C1 + int'(o_RAddr) + dcolTb * 256);
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [BI-1:0] hostPix(input int c, input int r);
    return BI'((c * 37 + r * 5 + 1) & 255);
  endfunction

  always @(negedge clk) begin
    if (rst) begin
      if (o_WValid) begin
        wrCount++;
        if (wrQ.size() == 0) checkOutput("unexpected_write", 1, 0);
        else begin
          wr_t e;
          e = wrQ.pop_front();
          checkOutput("wdata", 32'(o_Data), 32'(e.data));
          checkOutput("waddr", 32'(o_WAddr), 32'(e.addr));
        end
      end
      if (o_ResValid) begin
        resCount++;
        if (resQ.size() == 0) checkOutput("unexpected_result", 1, 0);
        else checkOutput("result", 32'(o_Res), 32'(resQ.pop_front()));
      end
      if (o_chblk) begin
        if (o_eop) chblkDrain++;
        else chblkLoad++;
      end
      if (o_sop) sopCycles++;
      if (o_Done) doneCount++;
      if ((o_chblk && (o_WValid || o_sop)) || (o_sop && o_eop)) overlaps++;
    end
  end

  task automatic applyStimulus(input int rows, input int cols, input bit gap,
                               input bit startInRun, input int stopAfter);
    int  passes, loaded, total, idx, cyc, cyc2;
    bit  pulsed;
    wr_t e;
    passes = (cols - 2 + N - 1) / N;
    loaded = N + 2 + N * (passes - 1);
    for (int c = 0; c < loaded; c++)
      for (int r = 0; r < rows; r++) begin
        e.data = (c < cols) ? hostPix(c, r) : '0;
        e.addr = BA'(r);
        wrQ.push_back(e);
      end
    if (stopAfter == 0)
      for (int p = 0; p < passes; p++)
        for (int c = 0; c < N; c++)
          for (int r = 0; r < rows; r++)
            resQ.push_back(BD'(32'h0C1 + r + 256 * c));
    wrCount = 0; resCount = 0; chblkLoad = 0; chblkDrain = 0; sopCycles = 0; doneCount = 0;
    total = (stopAfter > 0) ? stopAfter : rows * cols;
    pulsed = 0;

    @(negedge clk);
    i_Rows  = BA'(rows);
    i_Cols  = BC'(cols);
    i_Start = 1'b1;
    @(negedge clk);
    i_Start = 1'b0;

    fork
      begin
        idx = 0;
        cyc = 0;
        while (idx < total && cyc < 4000) begin
          @(negedge clk);
          i_Pix      = hostPix(idx / rows, idx % rows);
          i_PixValid = gap ? ((cyc % 2) == 0) : 1'b1;
          #1;
          if (o_PixReady && i_PixValid) idx++;
          cyc++;
        end
        if (idx < total) checkOutput("pixels_accepted", 32'(idx), 32'(total));
        if (stopAfter == 0) begin
          @(negedge clk);
          i_PixValid = 1'b0;
        end
      end
      begin
        if (stopAfter == 0) begin
          cyc2 = 0;
          while (doneCount == 0 && cyc2 < 5000) begin
            @(negedge clk);
            i_Start = 1'b0;
            if (startInRun && !pulsed && o_sop) begin
              i_Start = 1'b1;
              pulsed  = 1'b1;
            end
            cyc2++;
          end
          i_Start = 1'b0;
        end
      end
    join

    if (stopAfter == 0) begin
      repeat (20) @(negedge clk);
      if (startInRun) checkOutput("start_pulsed_in_run", 32'(pulsed), 1);
      checkOutput("done_pulses", 32'(doneCount), 1);
      checkOutput("writes", 32'(wrCount), 32'(loaded * rows));
      checkOutput("writes_pending", 32'(wrQ.size()), 0);
      checkOutput("results", 32'(resCount), 32'(N * rows * passes));
      checkOutput("results_pending", 32'(resQ.size()), 0);
      checkOutput("load_chblk", 32'(chblkLoad), 32'(loaded));
      checkOutput("drain_chblk", 32'(chblkDrain), 32'(N * passes));
      checkOutput("sop_cycles", 32'(sopCycles), 32'(rows * passes));
      checkOutput("busy_after_done", 32'(o_Busy), 0);
    end
  endtask

  initial begin
    #12;
    checkOutput("rst_pixready", 32'(o_PixReady), 0);
    checkOutput("rst_busy", 32'(o_Busy), 0);
    checkOutput("rst_done", 32'(o_Done), 0);
    checkOutput("rst_wvalid", 32'(o_WValid), 0);
    checkOutput("rst_chblk", 32'(o_chblk), 0);
    checkOutput("rst_sop", 32'(o_sop), 0);
    checkOutput("rst_eop", 32'(o_eop), 0);
    checkOutput("rst_resvalid", 32'(o_ResValid), 0);
    checkOutput("rst_data", 32'(o_Data), 0);
    checkOutput("rst_waddr", 32'(o_WAddr), 0);
    checkOutput("rst_raddr", 32'(o_RAddr), 0);
    checkOutput("rst_res", 32'(o_Res), 0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] image rows=4 cols=4 continuous");
    applyStimulus(4, 4, 1'b0, 1'b0, 0);
    $display("[TB] image rows=4 cols=7 with padding column");
    applyStimulus(4, 7, 1'b0, 1'b0, 0);
    $display("[TB] image rows=4 cols=4 with host gaps");
    applyStimulus(4, 4, 1'b1, 1'b0, 0);
    $display("[TB] image rows=3 cols=4 with start during run");
    applyStimulus(3, 4, 1'b0, 1'b1, 0);

    $display("[TB] reset after sixth pixel");
    applyStimulus(4, 4, 1'b0, 1'b0, 6);
    @(posedge clk);
    #1;
    i_PixValid = 1'b0;
    rst = 1'b0;
    #1;
    checkOutput("abort_wvalid", 32'(o_WValid), 0);
    checkOutput("abort_busy", 32'(o_Busy), 0);
    checkOutput("abort_pixready", 32'(o_PixReady), 0);
    checkOutput("abort_waddr", 32'(o_WAddr), 0);
    checkOutput("abort_data", 32'(o_Data), 0);
    wrQ.delete();
    resQ.delete();
    repeat (3) @(negedge clk);
    checkOutput("abort_no_done", 32'(doneCount), 0);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    applyStimulus(4, 4, 1'b0, 1'b0, 0);

    checkOutput("strobe_overlaps", 32'(overlaps), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/mcu_stream_sequencer.md
Name: mcu_stream_sequencer

Overview:
- Host-side initiator for the MCU control/data interface; drives the MCU the way the convolution datapath expects.
- Accepts a column-major pixel stream from the host over a valid/ready handshake and writes it into MCU banks column by column.
- Issues block-change (chblk), start-of-processing (sop) and end-of-processing (eop) sequences, then reads convolution results back and streams them to the host.

Parameters:
N, 2, number of parallel convolvers (MCU holds N+2 image banks)
BITS_IMAGEN, 8, pixel width
BITS_DATA, 13, convolution result width
BITS_ADDR, 10, bank address width (rows per column)
BITS_COLS, 10, image column count width

Ports:
clk  in  1  system clock
rst  in  1  asynchronous, active-low reset
i_Start  in  1  one-cycle start pulse; sampled only in IDLE
i_Rows  in  BITS_ADDR  rows per column; legal range 3..2^BITS_ADDR-1; latched on start
i_Cols  in  BITS_COLS  image columns; must be >= N+2; latched on start
i_Pix  in  BITS_IMAGEN  host pixel
i_PixValid  in  1  host pixel valid
o_PixReady  out  1  sequencer accepts pixel
o_Res  out  BITS_DATA  result to host
o_ResValid  out  1  result strobe; no backpressure
o_Busy  out  1  high outside IDLE
o_Done  out  1  one-cycle pulse at end of image
o_Data  out  BITS_IMAGEN  pixel to MCU
o_WValid  out  1  MCU write strobe
o_WAddr  out  BITS_ADDR  MCU write address (row)
o_RAddr  out  BITS_ADDR  MCU read address (row)
o_chblk  out  1  one-cycle bank-change pulse
o_sop  out  1  start of processing
o_eop  out  1  end of processing
i_MemRes  in  BITS_DATA  MCU result word; valid 1 cycle after o_RAddr

Behaviour:
- Reset: all outputs 0, FSM in IDLE, counters cleared. Reset mid-operation aborts immediately and drops any partial image; no o_Done.
- Pass count P = ceil((Cols-2)/N). The first load is N+2 columns; each later load is N columns.
- IDLE:
  - i_Start latches Rows/Cols, sets batch = N+2, pass = 0, goes to LOAD.
  - i_Start outside IDLE is ignored.
- LOAD:
  - If the column is a host column, o_PixReady = 1.
  - If the column index is >= Cols (padding), o_PixReady = 0 and zeros are generated internally, one per cycle.
  - Transfer occurs when o_PixReady && i_PixValid. The next cycle shows o_Data = pixel, o_WAddr = row, o_WValid = 1.
  - Row counter runs 0..Rows-1. After the last row → CHBLK.
- CHBLK:
  - o_chblk = 1 for exactly one cycle, occurring the cycle after the final o_WValid of the column.
  - Decrement batch. If batch != 0 → LOAD, else → RUN.
- RUN:
  - o_sop = 1 for exactly Rows consecutive cycles, with o_RAddr counting 0..Rows-1.
  - Then → DRAIN with o_sop = 0.
- DRAIN:
  - o_eop = 1 throughout.
  - For each of N result columns: o_RAddr counts 0..Rows-1, one per cycle, then one o_chblk cycle.
  - o_Res = registered i_MemRes, and o_ResValid is high 2 cycles after the matching o_RAddr. Exactly N*Rows results per pass, in column then row order.
  - After the final chblk, wait 2 cycles for the pipeline to flush, then:
    - if pass+1 < P: batch = N, → LOAD;
    - else → DONE.
- DONE: o_Done = 1 for one cycle, → IDLE.
- o_PixReady is 0 outside LOAD. Host gaps (i_PixValid low) stall LOAD only; addresses do not advance.
- Counters do not wrap: row counter compares against Rows-1; column counter has width BITS_COLS+1.
- o_sop and o_eop are never high simultaneously. o_chblk is never high with o_WValid or o_sop.

Test Plan:
- N=2, Rows=4, Cols=4, continuous valid →
  - 16 pixels accepted, 4 chblk pulses, o_WAddr 0,1,2,3 per column;
  - o_sop high 4 cycles;
  - eop phase returns 8 results (i_MemRes = 13'h0C1 → o_Res = 13'h0C1 2 cycles after o_RAddr) with 2 chblk pulses;
  - one o_Done pulse.
- Rows=4, Cols=7 → P=3:
  - host supplies 28 pixels;
  - last pass loads 1 host column, then 4 zero writes with o_PixReady = 0;
  - 24 results total.
- i_PixValid toggling every other cycle in LOAD → o_WValid follows accepted transfers only; o_WAddr sequence unchanged, no skipped rows.
- Reset (rst = 0) asserted after the 6th pixel → all outputs 0 asynchronously. A restart loads a full 4-column batch again from row 0.
- i_Start pulsed during RUN → no effect; o_Done count = 1 per image.
- Rows=3 (minimum) → o_sop width 3 cycles; 6 results per pass for N=2.
